// File: rtl/eh2_exu_mul_pipe.sv
// eh2_exu_mul_pipe: pipelined multi-threaded integer multiplier.
// E1 holds the issued operands and applies load-result bypass.
// E2 holds the sign-extended operands that feed the multiplier.
// STAGES-2 product registers follow, and the last one drives the result.
// A whole-pipe stall freezes every stage.
// A per-thread flush clears stage valids, including while stalled.
module eh2_exu_mul_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 3,
    parameter int TID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  in_valid,
    input  logic [TID_W-1:0]      in_tid,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  rs1_sign,
    input  logic                  rs2_sign,
    input  logic                  low,
    input  logic                  rs1_byp,
    input  logic                  rs2_byp,
    input  logic [DATA_W-1:0]     byp_data,
    input  logic                  stall,
    input  logic [2**TID_W-1:0]   flush,
    output logic                  out_valid,
    output logic [TID_W-1:0]      out_tid,
    output logic [DATA_W-1:0]     out
);

    localparam int NP = STAGES - 2;
    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] r_e1_a;
    logic [DATA_W-1:0] r_e1_b;
    logic              r_e1_s1;
    logic              r_e1_s2;
    logic              r_e1_low;
    logic              r_e1_byp1;
    logic              r_e1_byp2;
    logic [TID_W-1:0]  r_e1_tid;
    logic              r_e1_valid;

    logic [DATA_W:0]   r_e2_a;
    logic [DATA_W:0]   r_e2_b;
    logic              r_e2_low;
    logic [TID_W-1:0]  r_e2_tid;
    logic              r_e2_valid;

    logic [PW-1:0]     r_p_prod [NP];
    logic [TID_W-1:0]  r_p_tid  [NP];
    logic [NP-1:0]     r_p_low;
    logic [NP-1:0]     r_p_valid;

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [PW-1:0]     w_ext_a;
    logic [PW-1:0]     w_ext_b;
    logic [PW-1:0]     w_prod;

    // E1: capture issue; while stalled, latch the bypass data so it need only be valid once
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_e1_a     <= '0;
            r_e1_b     <= '0;
            r_e1_s1    <= 1'b0;
            r_e1_s2    <= 1'b0;
            r_e1_low   <= 1'b0;
            r_e1_byp1  <= 1'b0;
            r_e1_byp2  <= 1'b0;
            r_e1_tid   <= '0;
            r_e1_valid <= 1'b0;
        end else begin
            if (!stall && in_valid) begin
                r_e1_a    <= a;
                r_e1_b    <= b;
                r_e1_s1   <= rs1_sign;
                r_e1_s2   <= rs2_sign;
                r_e1_low  <= low;
                r_e1_byp1 <= rs1_byp;
                r_e1_byp2 <= rs2_byp;
                r_e1_tid  <= in_tid;
            end else if (stall && r_e1_valid) begin
                if (r_e1_byp1) begin
                    r_e1_a    <= byp_data;
                    r_e1_byp1 <= 1'b0;
                end
                if (r_e1_byp2) begin
                    r_e1_b    <= byp_data;
                    r_e1_byp2 <= 1'b0;
                end
            end
            if (!stall)
                r_e1_valid <= in_valid & ~flush[in_tid];
            else
                r_e1_valid <= r_e1_valid & ~flush[r_e1_tid];
        end
    end

    assign w_op_a = r_e1_byp1 ? byp_data : r_e1_a;
    assign w_op_b = r_e1_byp2 ? byp_data : r_e1_b;

    // E2: hold operands extended by one sign bit so one signed multiply covers all four ops
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_e2_a     <= '0;
            r_e2_b     <= '0;
            r_e2_low   <= 1'b0;
            r_e2_tid   <= '0;
            r_e2_valid <= 1'b0;
        end else begin
            if (!stall && r_e1_valid) begin
                r_e2_a   <= {r_e1_s1 & w_op_a[DATA_W-1], w_op_a};
                r_e2_b   <= {r_e1_s2 & w_op_b[DATA_W-1], w_op_b};
                r_e2_low <= r_e1_low;
                r_e2_tid <= r_e1_tid;
            end
            if (!stall)
                r_e2_valid <= r_e1_valid & ~flush[r_e1_tid];
            else
                r_e2_valid <= r_e2_valid & ~flush[r_e2_tid];
        end
    end

    // Only the low 2*DATA_W product bits are kept, and those depend only on
    // the low 2*DATA_W bits of the sign-extended operands.
    assign w_ext_a = {{(DATA_W-1){r_e2_a[DATA_W]}}, r_e2_a};
    assign w_ext_b = {{(DATA_W-1){r_e2_b[DATA_W]}}, r_e2_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Product register chain; data moves only behind a valid op, bubbles move as valid=0
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NP; i++) begin
                r_p_prod[i] <= '0;
                r_p_tid[i]  <= '0;
            end
            r_p_low   <= '0;
            r_p_valid <= '0;
        end else begin
            if (!stall && r_e2_valid) begin
                r_p_prod[0] <= w_prod;
                r_p_low[0]  <= r_e2_low;
                r_p_tid[0]  <= r_e2_tid;
            end
            if (!stall)
                r_p_valid[0] <= r_e2_valid & ~flush[r_e2_tid];
            else
                r_p_valid[0] <= r_p_valid[0] & ~flush[r_p_tid[0]];
            for (int i = 1; i < NP; i++) begin
                if (!stall && r_p_valid[i-1]) begin
                    r_p_prod[i] <= r_p_prod[i-1];
                    r_p_low[i]  <= r_p_low[i-1];
                    r_p_tid[i]  <= r_p_tid[i-1];
                end
                if (!stall)
                    r_p_valid[i] <= r_p_valid[i-1] & ~flush[r_p_tid[i-1]];
                else
                    r_p_valid[i] <= r_p_valid[i] & ~flush[r_p_tid[i]];
            end
        end
    end

    assign out_valid = r_p_valid[NP-1];
    assign out_tid   = r_p_tid[NP-1];
    assign out       = r_p_low[NP-1] ? r_p_prod[NP-1][DATA_W-1:0]
                                     : r_p_prod[NP-1][PW-1:DATA_W];

endmodule

// File: tb/tb_eh2_exu_mul_pipe.sv
// Testbench for eh2_exu_mul_pipe.
// It drives a default instance (32-bit, 3 stages, 2 threads) and a small
// instance (16-bit, 5 stages, 4 threads).
// The reference model keeps in-flight ops as a list.
// Each op carries its arithmetic result and the number of unstalled edges
// left before it shows at the output.
module tb_eh2_exu_mul_pipe;

    localparam int S0 = 3;
    localparam int S1 = 5;

    logic clk = 1'b0;
    logic rst_l = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid0, rs1_sign0, rs2_sign0, low0, rs1_byp0, rs2_byp0, stall0;
    logic [0:0]  in_tid0;
    logic [31:0] a0, b0, byp_data0;
    logic [1:0]  flush0;
    logic        out_valid0;
    logic [0:0]  out_tid0;
    logic [31:0] out0;

    logic        in_valid1, rs1_sign1, rs2_sign1, low1, rs1_byp1, rs2_byp1, stall1;
    logic [1:0]  in_tid1;
    logic [15:0] a1, b1, byp_data1;
    logic [3:0]  flush1;
    logic        out_valid1;
    logic [1:0]  out_tid1;
    logic [15:0] out1;

    eh2_exu_mul_pipe #(.DATA_W(32), .STAGES(S0), .TID_W(1)) u_dut0 (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid0), .in_tid(in_tid0),
        .a(a0), .b(b0), .rs1_sign(rs1_sign0), .rs2_sign(rs2_sign0), .low(low0),
        .rs1_byp(rs1_byp0), .rs2_byp(rs2_byp0), .byp_data(byp_data0),
        .stall(stall0), .flush(flush0),
        .out_valid(out_valid0), .out_tid(out_tid0), .out(out0)
    );

    eh2_exu_mul_pipe #(.DATA_W(16), .STAGES(S1), .TID_W(2)) u_dut1 (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid1), .in_tid(in_tid1),
        .a(a1), .b(b1), .rs1_sign(rs1_sign1), .rs2_sign(rs2_sign1), .low(low1),
        .rs1_byp(rs1_byp1), .rs2_byp(rs2_byp1), .byp_data(byp_data1),
        .stall(stall1), .flush(flush1),
        .out_valid(out_valid1), .out_tid(out_tid1), .out(out1)
    );

    typedef struct {
        int          dut;
        logic [63:0] res;
        int          tid;
        int          rem;
    } op_t;

    op_t         mq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] byp_next0 = '0;
    logic [15:0] byp_next1 = '0;

    function automatic logic [63:0] ref_mul(int w, logic [63:0] x, logic [63:0] y,
                                            bit sx, bit sy, bit lo);
        logic signed [129:0] ex, ey, p;
        logic [129:0]        t;
        logic [63:0]         mask;
        mask = (64'd1 << w) - 64'd1;
        ex = $signed({66'd0, x & mask});
        ey = $signed({66'd0, y & mask});
        if (sx && x[w-1]) ex = ex - (130'sd1 <<< w);
        if (sy && y[w-1]) ey = ey - (130'sd1 <<< w);
        p = ex * ey;
        t = p;
        if (!lo) t = t >> w;
        return t[63:0] & mask;
    endfunction

    function automatic void exp_out(input int d, output bit v, output logic [63:0] r, output int t);
        v = 1'b0; r = '0; t = 0;
        foreach (mq[i]) if (mq[i].dut == d && mq[i].rem == 0) begin
            v = 1'b1; r = mq[i].res; t = mq[i].tid;
        end
    endfunction

    task automatic tick();
        op_t      nq[$];
        op_t      o;
        bit       st;
        logic [3:0] fl;
        @(posedge clk);
        foreach (mq[i]) begin
            st = (mq[i].dut == 0) ? stall0 : stall1;
            fl = (mq[i].dut == 0) ? {2'b00, flush0} : flush1;
            if (st) begin
                if (!fl[mq[i].tid]) nq.push_back(mq[i]);
            end else if (mq[i].rem != 0 && !fl[mq[i].tid]) begin
                o = mq[i];
                o.rem = o.rem - 1;
                nq.push_back(o);
            end
        end
        if (!stall0 && in_valid0 && !flush0[in_tid0])
            nq.push_back('{dut: 0, tid: int'(in_tid0), rem: S0 - 1,
                res: ref_mul(32, 64'(rs1_byp0 ? byp_next0 : a0), 64'(rs2_byp0 ? byp_next0 : b0),
                             rs1_sign0, rs2_sign0, low0)});
        if (!stall1 && in_valid1 && !flush1[in_tid1])
            nq.push_back('{dut: 1, tid: int'(in_tid1), rem: S1 - 1,
                res: ref_mul(16, 64'(rs1_byp1 ? byp_next1 : a1), 64'(rs2_byp1 ? byp_next1 : b1),
                             rs1_sign1, rs2_sign1, low1)});
        mq = nq;
        #1;
    endtask

    task automatic idle();
        in_valid0 = 0; in_tid0 = '0; a0 = '0; b0 = '0; rs1_sign0 = 0; rs2_sign0 = 0;
        low0 = 0; rs1_byp0 = 0; rs2_byp0 = 0; byp_data0 = '0; stall0 = 0; flush0 = '0;
        in_valid1 = 0; in_tid1 = '0; a1 = '0; b1 = '0; rs1_sign1 = 0; rs2_sign1 = 0;
        low1 = 0; rs1_byp1 = 0; rs2_byp1 = 0; byp_data1 = '0; stall1 = 0; flush1 = '0;
    endtask

    task automatic test_reset();
        idle();
        #2 rst_l = 1'b0;
        #8;
        vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid0: got %b expected 0", out_valid0); end
        vectors++; if (out0 !== 32'd0) begin miscompares++; $display("FAIL reset_out0: got %h expected 0", out0); end
        vectors++; if (out_tid0 !== 1'b0) begin miscompares++; $display("FAIL reset_tid0: got %h expected 0", out_tid0); end
        vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid1: got %b expected 0", out_valid1); end
        vectors++; if (out1 !== 16'd0) begin miscompares++; $display("FAIL reset_out1: got %h expected 0", out1); end
        vectors++; if (out_tid1 !== 2'd0) begin miscompares++; $display("FAIL reset_tid1: got %h expected 0", out_tid1); end
        #3 rst_l = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_mul_basic();
        a0 = 32'd7; b0 = 32'd6; low0 = 1; in_tid0 = 1'b1; in_valid0 = 1;
        tick();
        in_valid0 = 0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid0 !== (k == 2)) begin
                miscompares++; $display("FAIL mul_latency k=%0d: got %b expected %b", k, out_valid0, (k == 2));
            end
            if (k == 2) begin
                vectors++;
                if (out0 !== 32'd42 || out_tid0 !== 1'b1) begin
                    miscompares++; $display("FAIL mul_result: got %h tid %h expected 0000002a tid 1", out0, out_tid0);
                end
            end
            tick();
        end
    endtask

    task automatic test_signedness();
        logic [31:0] exp_hi [3];
        exp_hi[0] = 32'hFFFFFFFE; exp_hi[1] = 32'h00000000; exp_hi[2] = 32'hFFFFFFFF;
        low0 = 0; in_tid0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid0 = (i < 3);
            a0 = 32'hFFFFFFFF;
            b0 = (i == 2) ? 32'd2 : 32'hFFFFFFFF;
            rs1_sign0 = (i != 0);
            rs2_sign0 = (i == 1);
            tick();
            if (i >= 2) begin
                vectors++;
                if (out_valid0 !== 1'b1 || out0 !== exp_hi[i-2]) begin
                    miscompares++; $display("FAIL signed_high op%0d: got v=%b %h expected v=1 %h", i - 2, out_valid0, out0, exp_hi[i-2]);
                end
            end
        end
        in_valid0 = 0; rs1_sign0 = 0; rs2_sign0 = 0;
        tick();
    endtask

    task automatic test_back_to_back_flush();
        bit          v;
        logic [63:0] r;
        int          t;
        logic [9:0]  exp_v_tbl;
        exp_v_tbl = 10'b0000011100;
        low0 = 1; b0 = 32'd3;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid0 = (cyc < 4) || (cyc == 6);
            in_tid0   = (cyc == 6) ? 1'b1 : 1'(cyc);
            a0        = (cyc == 6) ? 32'd99 : 32'(10 + cyc);
            flush0    = (cyc == 4 || cyc == 6) ? 2'b10 : 2'b00;
            tick();
            exp_out(0, v, r, t);
            vectors++;
            if (out_valid0 !== exp_v_tbl[cyc] || out_valid0 !== v) begin
                miscompares++; $display("FAIL flush_valid cyc=%0d: got %b expected %b", cyc, out_valid0, exp_v_tbl[cyc]);
            end
            if (v) begin
                vectors++;
                if (out0 !== r[31:0] || out_tid0 !== 1'(t)) begin
                    miscompares++; $display("FAIL flush_data cyc=%0d: got %h tid %h expected %h tid %0d", cyc, out0, out_tid0, r[31:0], t);
                end
            end
        end
        in_valid0 = 0; flush0 = 0;
    endtask

    task automatic test_stall_bypass();
        in_valid0 = 1; in_tid0 = 1'b0; a0 = 32'hDEAD; rs1_byp0 = 1; b0 = 32'd3; low0 = 1;
        byp_next0 = 32'd5;
        tick();
        in_valid0 = 0; rs1_byp0 = 0; a0 = 32'd1;
        for (int k = 1; k <= 4; k++) begin
            byp_data0 = (k == 1) ? 32'd5 : 32'd9;
            stall0 = (k <= 2);
            tick();
            vectors++;
            if (out_valid0 !== (k == 4)) begin
                miscompares++; $display("FAIL byp_latency k=%0d: got %b expected %b", k, out_valid0, (k == 4));
            end
        end
        vectors++;
        if (out0 !== 32'd15) begin miscompares++; $display("FAIL byp_result: got %h expected 0000000f", out0); end
        in_valid0 = 1; in_tid0 = 1'b1; stall0 = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (out_valid0 !== 1'b1 || out0 !== 32'd15) begin
                miscompares++; $display("FAIL stall_hold k=%0d: got v=%b %h expected v=1 0000000f", k, out_valid0, out0);
            end
        end
        in_valid0 = 0; stall0 = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (out_valid0 !== 1'b0) begin
                miscompares++; $display("FAIL stall_issue_ignored k=%0d: got %b expected 0", k, out_valid0);
            end
        end
    endtask

    task automatic test_reset_mid();
        low0 = 1; b0 = 32'd5;
        for (int i = 0; i < 3; i++) begin
            in_valid0 = 1; in_tid0 = 1'(i); a0 = 32'(i + 1);
            tick();
        end
        in_valid0 = 0;
        #2 rst_l = 1'b0;
        #1;
        mq.delete();
        vectors++;
        if (out_valid0 !== 1'b0 || out0 !== 32'd0) begin
            miscompares++; $display("FAIL reset_mid: got v=%b %h expected v=0 00000000", out_valid0, out0);
        end
        #1 rst_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_stale k=%0d: got %b expected 0", k, out_valid0); end
        end
        in_valid0 = 1; in_tid0 = 1'b1; a0 = 32'd123; b0 = 32'd2;
        tick();
        in_valid0 = 0;
        tick();
        tick();
        vectors++;
        if (out_valid0 !== 1'b1 || out0 !== 32'd246 || out_tid0 !== 1'b1) begin
            miscompares++; $display("FAIL reset_recover: got v=%b %h tid %h expected v=1 000000f6 tid 1", out_valid0, out0, out_tid0);
        end
        tick();
    endtask

    task automatic test_param_sweep();
        for (int tid = 0; tid < 4; tid++) begin
            a1 = 16'h8000; b1 = 16'h8000; rs1_sign1 = 1; rs2_sign1 = 1; low1 = 0;
            in_tid1 = 2'(tid); in_valid1 = 1;
            tick();
            in_valid1 = 0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                vectors++;
                if (out_valid1 !== (k == 4)) begin
                    miscompares++; $display("FAIL sweep_latency tid=%0d k=%0d: got %b expected %b", tid, k, out_valid1, (k == 4));
                end
            end
            vectors++;
            if (out1 !== 16'h4000 || out_tid1 !== 2'(tid)) begin
                miscompares++; $display("FAIL sweep_result tid=%0d: got %h tid %h expected 4000 tid %0d", tid, out1, out_tid1, tid);
            end
        end
        rs1_sign1 = 0; rs2_sign1 = 0;
        tick();
    endtask

    task automatic test_random();
        bit          v;
        logic [63:0] r;
        int          t;
        for (int cyc = 0; cyc < 400; cyc++) begin
            byp_data0 = byp_next0;
            byp_data1 = byp_next1;
            in_valid0 = ($urandom_range(0, 3) != 0);
            in_tid0   = 1'($urandom_range(0, 1));
            a0        = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            b0        = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            rs1_sign0 = 1'($urandom); rs2_sign0 = 1'($urandom); low0 = 1'($urandom);
            rs1_byp0  = ($urandom_range(0, 3) == 0);
            rs2_byp0  = ($urandom_range(0, 3) == 0);
            byp_next0 = $urandom;
            stall0    = ($urandom_range(0, 4) == 0);
            flush0    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            in_valid1 = ($urandom_range(0, 3) != 0);
            in_tid1   = 2'($urandom);
            a1        = 16'($urandom); b1 = 16'($urandom);
            rs1_sign1 = 1'($urandom); rs2_sign1 = 1'($urandom); low1 = 1'($urandom);
            rs1_byp1  = ($urandom_range(0, 3) == 0);
            rs2_byp1  = ($urandom_range(0, 3) == 0);
            byp_next1 = 16'($urandom);
            stall1    = ($urandom_range(0, 4) == 0);
            flush1    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            tick();
            exp_out(0, v, r, t);
            vectors++;
            if (out_valid0 !== v || (v && (out0 !== r[31:0] || out_tid0 !== 1'(t)))) begin
                miscompares++; $display("FAIL rand0 cyc=%0d: got v=%b %h tid %h expected v=%b %h tid %0d", cyc, out_valid0, out0, out_tid0, v, r[31:0], t);
            end
            exp_out(1, v, r, t);
            vectors++;
            if (out_valid1 !== v || (v && (out1 !== r[15:0] || out_tid1 !== 2'(t)))) begin
                miscompares++; $display("FAIL rand1 cyc=%0d: got v=%b %h tid %h expected v=%b %h tid %0d", cyc, out_valid1, out1, out_tid1, v, r[15:0], t);
            end
        end
        idle();
        for (int k = 0; k < 6; k++) tick();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_signedness();
        test_back_to_back_flush();
        test_stall_bypass();
        test_reset_mid();
        test_param_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
